// File: rtl/nrzi_serial_tx.sv
// NRZI serial transmitter: sync burst, then LSB-first payload
// with zero-run bit stuffing, one line bit per clock.
module nrzi_serial_tx #(
  parameter int DATA_W    = 8,
  parameter int SYNC_LEN  = 4,
  parameter int MAX_ZEROS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              line_out,
  output logic              line_active,
  output logic [1:0]        present_state
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int SW = $clog2(SYNC_LEN + 1);
  localparam int ZW = $clog2(MAX_ZEROS + 1);

  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] ALL_BITS  = BW'(DATA_W);
  localparam logic [SW-1:0] LAST_SYNC = SW'(SYNC_LEN - 1);
  localparam logic [ZW-1:0] LAST_ZERO = ZW'(MAX_ZEROS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    DATA  = 2'b10,
    STUFF = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [SW-1:0]       synccnt_q, synccnt_d;
  logic [ZW-1:0]       zcnt_q, zcnt_d;
  logic                line_q, line_d;
  logic                act_q, act_d;
  logic                emit;
  logic                bit_val;

  assign tx_ready      = (state_q == IDLE);
  assign line_out      = line_q;
  assign line_active   = act_q;
  assign present_state = state_q;

  // Next-state, shift/count updates and the bit emitted this edge
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    synccnt_d = synccnt_q;
    zcnt_d    = zcnt_q;
    emit      = 1'b0;
    bit_val   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shreg_d   = tx_data;
          bitcnt_d  = '0;
          synccnt_d = '0;
          zcnt_d    = '0;
          state_d   = SYNC;
        end
      end
      SYNC: begin
        emit      = 1'b1;
        bit_val   = 1'b1;
        synccnt_d = synccnt_q + SW'(1);
        if (synccnt_q == LAST_SYNC) begin
          zcnt_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        emit     = 1'b1;
        bit_val  = shreg_q[0];
        shreg_d  = shreg_q >> 1;
        bitcnt_d = bitcnt_q + BW'(1);
        zcnt_d   = bit_val ? '0 : zcnt_q + ZW'(1);
        if (!bit_val && zcnt_q == LAST_ZERO)
          state_d = STUFF;
        else if (bitcnt_q == LAST_BIT)
          state_d = IDLE;
      end
      STUFF: begin
        emit    = 1'b1;
        bit_val = 1'b1;
        zcnt_d  = '0;
        state_d = (bitcnt_q == ALL_BITS) ? IDLE : DATA;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level toggles on a 1, holds on a 0; held while idle
  always_comb begin
    line_d = line_q ^ (emit & bit_val);
    act_d  = emit;
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      synccnt_q <= '0;
      zcnt_q    <= '0;
      line_q    <= 1'b0;
      act_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      synccnt_q <= synccnt_d;
      zcnt_q    <= zcnt_d;
      line_q    <= line_d;
      act_q     <= act_d;
    end
  end

endmodule
